// File: rtl/score_glyph_drawer.sv
// Walks a latched three-digit 6x5 glyph bitmap and emits one frame-buffer pixel
// write per cycle, painting both set (foreground) and clear (background) bits.
module score_glyph_drawer #(
   parameter int unsigned X_W         = 8,
   parameter int unsigned Y_W         = 7,
   parameter int unsigned COLOUR_W    = 3,
   parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
   parameter int unsigned SCALE       = 1,
   parameter int unsigned DIGIT_PITCH = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [89:0]         score_display,
   input  logic [X_W-1:0]      origin_x,
   input  logic [Y_W-1:0]      origin_y,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [89:0]         bitmap_q;
   logic [X_W-1:0]      ox_q;
   logic [Y_W-1:0]      oy_q;
   // slot counts digits left to right (slot 0 = hundreds, d = 2 - slot)
   logic [1:0]          slot_q, row_q_unused_pad;
   logic [2:0]          row_q, col_q;
   logic [1:0]          sr_q, sc_q;
   logic                end_q;

   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

   logic                accept_s, emit_s, last_s, pix_on_s;
   logic [89:0]         bm_s;
   logic [X_W-1:0]      ox_s, x_sum_s;
   logic [Y_W-1:0]      oy_s, y_sum_s;
   logic [1:0]          slot_s, slot_n_s, sr_s, sr_n_s, sc_s, sc_n_s;
   logic [2:0]          row_s, row_n_s, col_s, col_n_s;
   logic [6:0]          bit_idx_s;
   logic                sc_last_s, col_last_s, sr_last_s, row_last_s, slot_last_s;

   assign row_q_unused_pad = 2'b00;

   always_comb begin
      accept_s = start && (state_q != S_DRAW);
      emit_s   = accept_s || ((state_q == S_DRAW) && !end_q);
   end

   // On the accepting edge the first pixel is taken straight from the inputs
   always_comb begin
      if (accept_s) begin
         bm_s   = score_display;
         ox_s   = origin_x;
         oy_s   = origin_y;
         slot_s = 2'd0;
         row_s  = 3'd0;
         sr_s   = 2'd0;
         col_s  = 3'd0;
         sc_s   = 2'd0;
      end else begin
         bm_s   = bitmap_q;
         ox_s   = ox_q;
         oy_s   = oy_q;
         slot_s = slot_q;
         row_s  = row_q;
         sr_s   = sr_q;
         col_s  = col_q;
         sc_s   = sc_q;
      end
   end

   always_comb begin
      // index = 30*d + 6*r + 5 - c, with d = 2 - slot
      bit_idx_s = 7'd65 + 7'(6 * row_s) - 7'(30 * slot_s) - 7'(col_s);
      pix_on_s  = bm_s[bit_idx_s];
      x_sum_s   = ox_s + X_W'(slot_s * DIGIT_PITCH * SCALE) + X_W'(col_s * SCALE) + X_W'(sc_s);
      y_sum_s   = oy_s + Y_W'(row_s * SCALE) + Y_W'(sr_s);
   end

   // Nested scan counter advance: slot > row > sub-row > column > sub-column
   always_comb begin
      sc_last_s   = (sc_s == 2'(SCALE - 1));
      col_last_s  = (col_s == 3'd5);
      sr_last_s   = (sr_s == 2'(SCALE - 1));
      row_last_s  = (row_s == 3'd4);
      slot_last_s = (slot_s == 2'd2);
      last_s      = sc_last_s && col_last_s && sr_last_s && row_last_s && slot_last_s;
      slot_n_s    = slot_s;
      row_n_s     = row_s;
      sr_n_s      = sr_s;
      col_n_s     = col_s;
      sc_n_s      = sc_s + 2'd1;
      if (sc_last_s) begin
         sc_n_s  = 2'd0;
         col_n_s = col_s + 3'd1;
         if (col_last_s) begin
            col_n_s = 3'd0;
            sr_n_s  = sr_s + 2'd1;
            if (sr_last_s) begin
               sr_n_s  = 2'd0;
               row_n_s = row_s + 3'd1;
               if (row_last_s) begin
                  row_n_s  = 3'd0;
                  slot_n_s = slot_s + 2'd1;
               end else begin
                  slot_n_s = slot_s;
               end
            end else begin
               row_n_s = row_s;
            end
         end else begin
            sr_n_s = sr_s;
         end
      end else begin
         col_n_s = col_s;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept_s ? S_DRAW : S_IDLE;
         S_DRAW:  state_d = end_q ? S_DONE : S_DRAW;
         S_DONE:  state_d = accept_s ? S_DRAW : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output next values; coordinates and colour hold whenever no pixel is emitted
   always_comb begin
      plot_d = emit_s;
      busy_d = emit_s;
      done_d = (state_q == S_DRAW) && end_q;
      if (emit_s) begin
         x_d      = x_sum_s;
         y_d      = y_sum_s;
         colour_d = pix_on_s ? FG_COLOUR : BG_COLOUR;
      end else begin
         x_d      = x_q;
         y_d      = y_q;
         colour_d = colour_q;
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bitmap_q <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         slot_q   <= 2'd0;
         row_q    <= 3'd0;
         sr_q     <= 2'd0;
         col_q    <= 3'd0;
         sc_q     <= 2'd0;
         end_q    <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         if (accept_s) begin
            bitmap_q <= score_display;
            ox_q     <= origin_x;
            oy_q     <= origin_y;
         end else begin
            bitmap_q <= bitmap_q;
            ox_q     <= ox_q;
            oy_q     <= oy_q;
         end
         if (emit_s) begin
            slot_q <= slot_n_s;
            row_q  <= row_n_s;
            sr_q   <= sr_n_s;
            col_q  <= col_n_s;
            sc_q   <= sc_n_s;
            end_q  <= last_s;
         end else begin
            slot_q <= slot_q;
            row_q  <= row_q;
            sr_q   <= sr_q;
            col_q  <= col_q;
            sc_q   <= sc_q;
            end_q  <= end_q;
         end
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_score_glyph_drawer.sv
// Directed bench for score_glyph_drawer: one SCALE=1 and one SCALE=2 instance.
module tb_score_glyph_drawer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start1, start2;
   logic [89:0] sd1, sd2;
   logic [7:0]  ox1, ox2;
   logic [6:0]  oy1, oy2;
   logic [7:0]  x1, x2;
   logic [6:0]  y1, y2;
   logic [2:0]  c1, c2;
   logic        p1, p2, b1, b2, dn1, dn2;

   score_glyph_drawer #(.SCALE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .score_display(sd1),
      .origin_x(ox1), .origin_y(oy1), .x(x1), .y(y1), .colour(c1),
      .plot(p1), .busy(b1), .done(dn1));

   score_glyph_drawer #(.SCALE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .score_display(sd2),
      .origin_x(ox2), .origin_y(oy2), .x(x2), .y(y2), .colour(c2),
      .plot(p2), .busy(b2), .done(dn2));

   int n_cmp = 0;
   int n_bad = 0;
   int px [0:399];
   int py [0:399];
   int pc [0:399];
   int nplot, nfg, gap_err;
   logic done_seen;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called on a negedge; start is seen at the following posedge.
   task automatic start_pass(input int sel, input logic [89:0] bm, input logic [7:0] ox,
                             input logic [6:0] oy);
      if (sel == 1) begin
         sd1 = bm; ox1 = ox; oy1 = oy; start1 = 1'b1;
      end else begin
         sd2 = bm; ox2 = ox; oy2 = oy; start2 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // Samples from the current negedge until done (bounded); returns on the done cycle.
   task automatic capture(input int sel);
      nplot = 0; nfg = 0; gap_err = 0; done_seen = 1'b0;
      for (int i = 0; i < 420; i++) begin
         logic pl, bs, dn;
         int xx, yy, cc;
         if (sel == 1) begin
            pl = p1; bs = b1; dn = dn1; xx = 32'(x1); yy = 32'(y1); cc = 32'(c1);
         end else begin
            pl = p2; bs = b2; dn = dn2; xx = 32'(x2); yy = 32'(y2); cc = 32'(c2);
         end
         if (dn) begin
            done_seen = !pl && !bs;
            break;
         end
         if (pl) begin
            if (nplot < 400) begin
               px[nplot] = xx; py[nplot] = yy; pc[nplot] = cc;
            end
            nplot++;
            if (cc == 7) nfg++;
            if (!bs) gap_err++;
         end else begin
            gap_err++;
         end
         @(negedge clk);
      end
   endtask

   logic [89:0] bm;
   logic [5:0]  zero_rows [0:4];
   int f1, f2;

   initial begin
      reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
      sd1 = '0; sd2 = '0; ox1 = '0; ox2 = '0; oy1 = '0; oy2 = '0;
      repeat (3) @(negedge clk);
      check_val("rst_plot", 32'(p1), 32'd0);
      check_val("rst_busy", 32'(b1), 32'd0);
      check_val("rst_done", 32'(dn1), 32'd0);
      check_val("rst_xyc", {8'd0, 3'(c1), 7'(y1), 6'd0, 8'(x1)}, 32'd0);
      check_val("rst_plot2", 32'(p2), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // A: single bit at hundreds digit, row 0, column 0 -> first pixel
      bm = '0; bm[65] = 1'b1;
      start_pass(1, bm, 8'd10, 7'd5);
      capture(1);
      check_val("A_nplot", nplot, 32'd90);
      check_val("A_done", 32'(done_seen), 32'd1);
      check_val("A_gap", gap_err, 32'd0);
      check_val("A_nfg", nfg, 32'd1);
      check_val("A_p0", {px[0][15:0], py[0][7:0], pc[0][7:0]}, {16'd10, 8'd5, 8'd7});
      check_val("A_p89", {px[89][15:0], py[89][7:0], pc[89][7:0]}, {16'd27, 8'd9, 8'd0});
      check_val("A_hold", {24'd0, x1}, 32'd27);
      @(negedge clk);
      check_val("A_idle", {30'd0, b1, dn1}, 32'd0);

      // B: bits 89 (d2 r4 c0), 0 (d0 r0 c5), 24 (d0 r4 c5)
      bm = '0; bm[89] = 1'b1; bm[0] = 1'b1; bm[24] = 1'b1;
      start_pass(1, bm, 8'd20, 7'd30);
      capture(1);
      check_val("B_nfg", nfg, 32'd3);
      check_val("B_b89", {px[24][15:0], py[24][7:0], pc[24][7:0]}, {16'd20, 8'd34, 8'd7});
      check_val("B_b0", {px[65][15:0], py[65][7:0], pc[65][7:0]}, {16'd37, 8'd30, 8'd7});
      check_val("B_b24", {px[89][15:0], py[89][7:0], pc[89][7:0]}, {16'd37, 8'd34, 8'd7});

      // C: "000"
      zero_rows[0] = 6'b001100; zero_rows[1] = 6'b010010; zero_rows[2] = 6'b010110;
      zero_rows[3] = 6'b011010; zero_rows[4] = 6'b001100;
      bm = '0;
      for (int d = 0; d < 3; d++)
         for (int r = 0; r < 5; r++)
            bm[30*d + 6*r +: 6] = zero_rows[r];
      start_pass(1, bm, 8'd0, 7'd0);
      capture(1);
      check_val("C_nplot", nplot, 32'd90);
      check_val("C_nfg", nfg, 32'($countones(bm)));
      f1 = -1; f2 = -1;
      for (int i = 0; i < 90; i++) begin
         if (pc[i] == 7 && f1 < 0) f1 = i;
         else if (pc[i] == 7 && f2 < 0) f2 = i;
      end
      check_val("C_fg1", {px[f1][15:0], py[f1][15:0]}, {16'd2, 16'd0});
      check_val("C_fg2", {px[f2][15:0], py[f2][15:0]}, {16'd3, 16'd0});

      // D: inputs disturbed at plot #20 do not affect the pass
      bm = '0; bm[65] = 1'b1;
      fork
         begin
            repeat (20) @(negedge clk);
            sd1 = ~sd1; ox1 = 8'd99; oy1 = 7'd99; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
         end
         begin
            start_pass(1, bm, 8'd10, 7'd5);
            capture(1);
         end
      join
      check_val("D_nplot", nplot, 32'd90);
      check_val("D_nfg", nfg, 32'd1);
      check_val("D_p89", {px[89][15:0], py[89][15:0]}, {16'd27, 16'd9});

      // D2: start held high gives back-to-back passes
      sd1 = bm; ox1 = 8'd10; oy1 = 7'd5; start1 = 1'b1;
      @(negedge clk);
      capture(1);
      check_val("D2_first", nplot, 32'd90);
      check_val("D2_done", 32'(done_seen), 32'd1);
      @(negedge clk);
      check_val("D2_restart", {30'd0, p1, b1}, 32'd3);
      check_val("D2_p0", {24'd0, x1}, 32'd10);
      start1 = 1'b0;
      capture(1);
      check_val("D2_second", nplot, 32'd90);

      // E: reset mid-draw at plot #40
      @(negedge clk);
      start_pass(1, bm, 8'd10, 7'd5);
      repeat (39) @(negedge clk);
      check_val("E_pre", 32'(p1), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_val("E_rst", {29'd0, p1, b1, dn1}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_val("E_quiet", {29'd0, p1, b1, dn1}, 32'd0);
      start_pass(1, bm, 8'd10, 7'd5);
      capture(1);
      check_val("E_full", nplot, 32'd90);

      // E2: reset and start together, reset wins
      @(negedge clk);
      reset = 1'b1; start1 = 1'b1;
      @(negedge clk);
      reset = 1'b0; start1 = 1'b0;
      check_val("E2_rs", {30'd0, p1, b1}, 32'd0);
      @(negedge clk);
      check_val("E2_after", 32'(p1), 32'd0);

      // F: x wraps modulo 256
      bm = '0; bm[24] = 1'b1;
      start_pass(1, bm, 8'd250, 7'd0);
      capture(1);
      check_val("F_wrap", {px[89][15:0], py[89][7:0], pc[89][7:0]}, {16'd11, 8'd4, 8'd7});

      // G: SCALE=2
      @(negedge clk);
      bm = '0; bm[65] = 1'b1;
      start_pass(2, bm, 8'd0, 7'd0);
      capture(2);
      check_val("G_nplot", nplot, 32'd360);
      check_val("G_done", 32'(done_seen), 32'd1);
      check_val("G_nfg", nfg, 32'd4);
      check_val("G_p0", {px[0][7:0], py[0][7:0], pc[0][7:0], 8'd0}, {8'd0, 8'd0, 8'd7, 8'd0});
      check_val("G_p1", {px[1][7:0], py[1][7:0], pc[1][7:0], 8'd0}, {8'd1, 8'd0, 8'd7, 8'd0});
      check_val("G_p12", {px[12][7:0], py[12][7:0], pc[12][7:0], 8'd0}, {8'd0, 8'd1, 8'd7, 8'd0});
      check_val("G_p13", {px[13][7:0], py[13][7:0], pc[13][7:0], 8'd0}, {8'd1, 8'd1, 8'd7, 8'd0});
      check_val("G_last", {px[359][15:0], py[359][15:0]}, {16'd35, 16'd9});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
